// File: rtl/frame_buffer_reader.sv
// Reads a stored frame from a synchronous RAM and replays it as vsyn/href/clken/data with programmable blanking.
// Optional build macro FRAME_READER_PATTERN_EN adds pattern_en and an 8-band colour bar source.
module frame_buffer_reader #(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 640,
  parameter int IMG_DATAW = 16,
  parameter int H_BLANK   = 16,
  parameter int V_BACK    = 8,
  parameter int V_FRONT   = 8,
  parameter int RD_LAT    = 1,
  localparam int XW = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1,
  localparam int YW = (IMG_VDISP > 1) ? $clog2(IMG_VDISP) : 1
) (
  input  logic                 pix_clk,
  input  logic                 sys_rst,
  input  logic                 frame_start,
`ifdef FRAME_READER_PATTERN_EN
  input  logic                 pattern_en,
`endif
  output logic                 frame_busy,
  output logic                 frame_done,
  output logic                 rd_en,
  output logic [XW-1:0]        rd_xaddr,
  output logic [YW-1:0]        rd_yaddr,
  input  logic [IMG_DATAW-1:0] rd_data,
  output logic                 post_frame_vsyn,
  output logic                 post_frame_href,
  output logic                 post_frame_clken,
  output logic [IMG_DATAW-1:0] post_frame_data
);

  localparam int CMAX = ((V_BACK > H_BLANK) ? V_BACK : H_BLANK) > V_FRONT ?
                        ((V_BACK > H_BLANK) ? V_BACK : H_BLANK) : V_FRONT;
  localparam int CW = $clog2(CMAX + 1);

  typedef enum logic [2:0] {IDLE, VBACK, ACTIVE, HBLANK, VFRONT} state_t;

  state_t          state, state_n;
  logic [XW-1:0]   x, x_n;
  logic [YW-1:0]   y, y_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [RD_LAT:0] act_pipe;
  logic [RD_LAT:0] vs_pipe;
  logic            pat_r;

  always_comb begin
    state_n = state;
    x_n     = x;
    y_n     = y;
    cnt_n   = cnt;
    case (state)
      IDLE:
        if (frame_start) begin
          state_n = VBACK;
          x_n     = '0;
          y_n     = '0;
          cnt_n   = '0;
        end
      VBACK:
        if (cnt == CW'(V_BACK - 1)) begin
          state_n = ACTIVE;
          cnt_n   = '0;
        end else cnt_n = cnt + 1'b1;
      ACTIVE:
        if (x == XW'(IMG_HDISP - 1)) begin
          x_n     = '0;
          state_n = HBLANK;
        end else x_n = x + 1'b1;
      HBLANK:
        if (cnt == CW'(H_BLANK - 1)) begin
          cnt_n = '0;
          if (y == YW'(IMG_VDISP - 1)) begin
            y_n     = '0;
            state_n = VFRONT;
          end else begin
            y_n     = y + 1'b1;
            state_n = ACTIVE;
          end
        end else cnt_n = cnt + 1'b1;
      VFRONT:
        if (cnt == CW'(V_FRONT - 1)) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else cnt_n = cnt + 1'b1;
      default: state_n = IDLE;
    endcase
  end

  // Stage 0 of each pipe lines up with the state register; stage RD_LAT lines up with rd_data.
  always_ff @(posedge pix_clk) begin
    if (sys_rst) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      cnt        <= '0;
      frame_busy <= 1'b0;
      frame_done <= 1'b0;
      act_pipe   <= '0;
      vs_pipe    <= '0;
    end else begin
      state       <= state_n;
      x           <= x_n;
      y           <= y_n;
      cnt         <= cnt_n;
      frame_busy  <= (state_n != IDLE);
      frame_done  <= (state == VFRONT) && (state_n == IDLE);
      act_pipe[0] <= (state_n == ACTIVE);
      vs_pipe[0]  <= (state_n == VBACK) || (state_n == ACTIVE) || (state_n == HBLANK);
      for (int i = 1; i <= RD_LAT; i++) begin
        act_pipe[i] <= act_pipe[i-1];
        vs_pipe[i]  <= vs_pipe[i-1];
      end
    end
  end

  assign rd_en            = act_pipe[0] & ~pat_r;
  assign rd_xaddr         = x;
  assign rd_yaddr         = y;
  assign post_frame_vsyn  = vs_pipe[RD_LAT];
  assign post_frame_href  = act_pipe[RD_LAT];
  assign post_frame_clken = act_pipe[RD_LAT];

`ifdef FRAME_READER_PATTERN_EN
  localparam int BAND_W = (IMG_HDISP >= 8) ? IMG_HDISP / 8 : 1;

  logic [RD_LAT:1][XW-1:0] x_pipe;
  logic [IMG_DATAW-1:0]    pat_pix;
  int                      band;

  always_ff @(posedge pix_clk) begin
    if (sys_rst) begin
      pat_r  <= 1'b0;
      x_pipe <= '0;
    end else begin
      if (state == IDLE && frame_start) pat_r <= pattern_en;
      x_pipe[1] <= x;
      for (int i = 2; i <= RD_LAT; i++) x_pipe[i] <= x_pipe[i-1];
    end
  end

  always_comb begin
    band = int'(x_pipe[RD_LAT]) / BAND_W;
    case (band)
      0:       pat_pix = IMG_DATAW'(16'hFFFF);
      1:       pat_pix = IMG_DATAW'(16'hFFE0);
      2:       pat_pix = IMG_DATAW'(16'h07FF);
      3:       pat_pix = IMG_DATAW'(16'h07E0);
      4:       pat_pix = IMG_DATAW'(16'hF81F);
      5:       pat_pix = IMG_DATAW'(16'hF800);
      6:       pat_pix = IMG_DATAW'(16'h001F);
      default: pat_pix = IMG_DATAW'(16'h0000);
    endcase
  end

  assign post_frame_data = act_pipe[RD_LAT] ? (pat_r ? pat_pix : rd_data) : '0;
`else
  assign pat_r = 1'b0;
  // The RAM's own output register is the data stage, so gating it with the delayed enable keeps data and clken aligned.
  assign post_frame_data = act_pipe[RD_LAT] ? rd_data : '0;
`endif

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Directed bench: 4x3 frame at RD_LAT 1 and 2 side by side; a 16-wide pattern instance when FRAME_READER_PATTERN_EN is set.
module tb_frame_buffer_reader;

  logic        pix_clk = 1'b0;
  logic        sys_rst;
  logic        frame_start;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 pix_clk = ~pix_clk;

  logic        busy1, done1, rden1, vs1, hr1, ce1;
  logic [1:0]  xa1, ya1;
  logic [15:0] rdd1, pd1;
  logic        busy2, done2, rden2, vs2, hr2, ce2;
  logic [1:0]  xa2, ya2;
  logic [15:0] rdd2, ram2_q, pd2;

`ifdef FRAME_READER_PATTERN_EN
  logic        pat_off = 1'b0;
  logic        pattern_en;
  logic        frame_start_p;
  logic        busyp, donep, rdenp, vsp, hrp, cep;
  logic [3:0]  xap;
  logic [1:0]  yap;
  logic [15:0] rddp, pdp;
  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};
`endif

  frame_buffer_reader #(.IMG_HDISP(4), .IMG_VDISP(3), .IMG_DATAW(16), .H_BLANK(2),
                        .V_BACK(3), .V_FRONT(2), .RD_LAT(1)) dut1 (
    .pix_clk(pix_clk), .sys_rst(sys_rst), .frame_start(frame_start),
`ifdef FRAME_READER_PATTERN_EN
    .pattern_en(pat_off),
`endif
    .frame_busy(busy1), .frame_done(done1), .rd_en(rden1), .rd_xaddr(xa1), .rd_yaddr(ya1),
    .rd_data(rdd1), .post_frame_vsyn(vs1), .post_frame_href(hr1), .post_frame_clken(ce1),
    .post_frame_data(pd1));

  frame_buffer_reader #(.IMG_HDISP(4), .IMG_VDISP(3), .IMG_DATAW(16), .H_BLANK(2),
                        .V_BACK(3), .V_FRONT(2), .RD_LAT(2)) dut2 (
    .pix_clk(pix_clk), .sys_rst(sys_rst), .frame_start(frame_start),
`ifdef FRAME_READER_PATTERN_EN
    .pattern_en(pat_off),
`endif
    .frame_busy(busy2), .frame_done(done2), .rd_en(rden2), .rd_xaddr(xa2), .rd_yaddr(ya2),
    .rd_data(rdd2), .post_frame_vsyn(vs2), .post_frame_href(hr2), .post_frame_clken(ce2),
    .post_frame_data(pd2));

  // RAM models: word at (x, y) is {y, x}
  always_ff @(posedge pix_clk) begin
    rdd1   <= {8'(ya1), 8'(xa1)};
    ram2_q <= {8'(ya2), 8'(xa2)};
    rdd2   <= ram2_q;
  end

`ifdef FRAME_READER_PATTERN_EN
  frame_buffer_reader #(.IMG_HDISP(16), .IMG_VDISP(3), .IMG_DATAW(16), .H_BLANK(2),
                        .V_BACK(3), .V_FRONT(2), .RD_LAT(1)) dutp (
    .pix_clk(pix_clk), .sys_rst(sys_rst), .frame_start(frame_start_p), .pattern_en(pattern_en),
    .frame_busy(busyp), .frame_done(donep), .rd_en(rdenp), .rd_xaddr(xap), .rd_yaddr(yap),
    .rd_data(rddp), .post_frame_vsyn(vsp), .post_frame_href(hrp), .post_frame_clken(cep),
    .post_frame_data(pdp));

  always_ff @(posedge pix_clk) rddp <= {8'(yap), 8'(xap)};
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge pix_clk);
  endtask

  // Line l is read in cycles 4+6l .. 7+6l after the start cycle (period = 4 pixels + 2 blank).
  function automatic bit act_at(input int r);
    for (int l = 0; l < 3; l++)
      if (r >= 4 + 6*l && r <= 7 + 6*l) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [15:0] pix_at(input int r);
    for (int l = 0; l < 3; l++)
      if (r >= 4 + 6*l && r <= 7 + 6*l) return 16'(l*256 + (r - 4 - 6*l));
    return 16'h0;
  endfunction

  task automatic trace_chk(input int r);
    logic [15:0] p;
    p = pix_at(r);
    chk("busy1", busy1, 32'(r >= 1 && r <= 23));
    chk("done1", done1, 32'(r == 24));
    chk("rd_en1", rden1, 32'(act_at(r)));
    if (act_at(r)) begin
      chk("xaddr1", xa1, 32'(p[7:0]));
      chk("yaddr1", ya1, 32'(p[15:8]));
    end
    chk("clken1", ce1, 32'(act_at(r-1)));
    chk("href1", hr1, 32'(act_at(r-1)));
    chk("data1", pd1, 32'(pix_at(r-1)));
    chk("vsyn1", vs1, 32'(r >= 2 && r <= 22));
    chk("busy2", busy2, 32'(r >= 1 && r <= 23));
    chk("done2", done2, 32'(r == 24));
    chk("clken2", ce2, 32'(act_at(r-2)));
    chk("data2", pd2, 32'(pix_at(r-2)));
    chk("vsyn2", vs2, 32'(r >= 3 && r <= 23));
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, "_busy"}, {busy1, busy2}, 0);
    chk({tag, "_done"}, {done1, done2}, 0);
    chk({tag, "_rden"}, {rden1, rden2}, 0);
    chk({tag, "_sync"}, {vs1, hr1, ce1, vs2, hr2, ce2}, 0);
    chk({tag, "_addr"}, {xa1, ya1, xa2, ya2}, 0);
    chk({tag, "_data"}, {pd1, pd2}, 0);
  endtask

  initial begin
    int nce, nce2, nd;
    sys_rst     = 1'b1;
    frame_start = 1'b0;
`ifdef FRAME_READER_PATTERN_EN
    pattern_en    = 1'b0;
    frame_start_p = 1'b0;
`endif
    repeat (3) tick();
    zero_chk("reset");
    sys_rst = 1'b0;
    repeat (2) tick();

    // single frame, then count pulses
    frame_start = 1'b1;
    nce = 0; nce2 = 0; nd = 0;
    for (int r = 0; r <= 30; r++) begin
      if (r == 1) frame_start = 1'b0;
      if (r <= 26) trace_chk(r);
      nce += int'(ce1); nce2 += int'(ce2); nd += int'(done1);
      tick();
    end
    chk("single_clken1", nce, 12);
    chk("single_clken2", nce2, 12);
    chk("single_done", nd, 1);

    // start pulsed again mid-frame is ignored
    frame_start = 1'b1;
    nce = 0; nd = 0;
    for (int r = 0; r <= 40; r++) begin
      if (r == 1 || r == 11) frame_start = 1'b0;
      if (r == 10) frame_start = 1'b1;
      if (r <= 26) trace_chk(r);
      nce += int'(ce1); nd += int'(done1);
      tick();
    end
    chk("ignored_clken", nce, 12);
    chk("ignored_done", nd, 1);

    // start held: two frames back to back, one IDLE cycle apart
    frame_start = 1'b1;
    nce = 0; nd = 0;
    for (int r = 0; r <= 59; r++) begin
      if (r == 48) frame_start = 1'b0;
      if (r <= 23) trace_chk(r);
      if (r == 24) chk("b2b_gap_busy", busy1, 0);
      if (r == 25) chk("b2b_busy_rise", busy1, 1);
      if (r == 48) chk("b2b_done2", done1, 1);
      nce += int'(ce1); nd += int'(done1);
      tick();
    end
    chk("b2b_clken", nce, 24);
    chk("b2b_done", nd, 2);

    // reset mid line 1, then a clean restart
    frame_start = 1'b1;
    for (int r = 0; r <= 12; r++) begin
      if (r == 1) frame_start = 1'b0;
      if (r == 12) begin
        chk("pre_rst_clken", ce1, 1);
        sys_rst = 1'b1;
      end
      tick();
    end
    zero_chk("midrst");
    sys_rst = 1'b0;
    repeat (2) tick();
    frame_start = 1'b1;
    for (int r = 0; r <= 26; r++) begin
      if (r == 1) frame_start = 1'b0;
      trace_chk(r);
      tick();
    end

`ifdef FRAME_READER_PATTERN_EN
    // colour bars on 16-wide frame; pattern_en drop mid-frame must not matter
    pattern_en    = 1'b1;
    frame_start_p = 1'b1;
    nce = 0;
    for (int r = 0; r <= 62; r++) begin
      if (r == 1) frame_start_p = 1'b0;
      if (r == 10) pattern_en = 1'b0;
      nce += int'(rdenp);
      if (r >= 5 && r <= 20) chk("bar_line0", pdp, 32'(bars[(r-5)/2]));
      if (r == 23) chk("bar_line1_x0", pdp, 32'h0000FFFF);
      if (r == 60) chk("bar_done", donep, 1);
      tick();
    end
    chk("bar_rd_en_cnt", nce, 0);
    frame_start_p = 1'b1;
    for (int r = 0; r <= 6; r++) begin
      if (r == 1) frame_start_p = 1'b0;
      if (r == 4) chk("ram_mode_rd_en", rdenp, 1);
      if (r == 6) chk("ram_mode_data", pdp, 32'h00000001);
      tick();
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
